// File: rtl/pc_pkg.sv
// Shared types and constants for the program counter / fetch sequencer.
// The jump table is regenerated by the assembler flow; index order matches the instruction field.
package pc_pkg;

    localparam int PC_W     = 8;
    localparam int LUT_AW   = 4;
    localparam int PROG_LEN = 256;
    localparam int CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_e;

    // One table serves both absolute targets and two's-complement offsets.
    localparam logic [PC_W-1:0] JUMP_LUT [2**LUT_AW] = '{
        8'h04, 8'h14, 8'h02, 8'hFC,
        8'hF0, 8'h80, 8'h00, 8'h07,
        8'h08, 8'hFF, 8'h28, 8'hF8,
        8'h30, 8'h01, 8'hC0, 8'hFE
    };

endpackage

// File: rtl/prog_counter_if.sv
// Fetch-sequencer bus: controller-side strobes in, PC and status out.
interface prog_counter_if #(
    parameter int PC_W   = pc_pkg::PC_W,
    parameter int LUT_AW = pc_pkg::LUT_AW,
    parameter int CNT_W  = pc_pkg::CNT_W
);

    logic              start;
    logic              stall;
    logic              branch_en;
    logic              jump_abs;
    logic [LUT_AW-1:0] lut_idx;
    logic              halt;
    logic [PC_W-1:0]   PC;
    logic              done;
    logic              running;
    logic [CNT_W-1:0]  instr_count;

    modport master (
        output start, stall, branch_en, jump_abs, lut_idx, halt,
        input  PC, done, running, instr_count
    );

    modport slave (
        input  start, stall, branch_en, jump_abs, lut_idx, halt,
        output PC, done, running, instr_count
    );

endinterface

// File: rtl/jump_lut.sv
// Combinational jump-target table: index from the instruction field to a PC-wide entry.
module jump_lut
    import pc_pkg::*;
(
    input  logic [LUT_AW-1:0] idx,
    output logic [PC_W-1:0]   entry
);

    assign entry = JUMP_LUT[idx];

endmodule

// File: rtl/prog_counter.sv
// Program counter and start/done sequencer feeding the instruction ROM address.
// Taken branches resolve through jump_lut as either an absolute target or a relative offset.
module prog_counter #(
    parameter int PC_W     = pc_pkg::PC_W,
    parameter int LUT_AW   = pc_pkg::LUT_AW,
    parameter int PROG_LEN = pc_pkg::PROG_LEN,
    parameter int CNT_W    = pc_pkg::CNT_W
) (
    input  logic          clk,
    input  logic          reset_n,
    prog_counter_if.slave bus
);

    import pc_pkg::*;

    localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

    pc_state_e        state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             running_q, running_d;

    logic [PC_W-1:0]  lut_entry;
    logic [CNT_W-1:0] cnt_inc;

    jump_lut u_jump_lut (
        .idx   (bus.lut_idx),
        .entry (lut_entry)
    );

    // Retired-fetch count sticks at all-ones instead of wrapping.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                pc_d = '0;
                if (bus.start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (bus.start) begin
                    pc_d  = '0;
                    cnt_d = '0;
                end else if (bus.stall) begin
                    pc_d = pc_q;
                end else if (bus.halt) begin
                    state_d = DONE;
                    cnt_d   = cnt_inc;
                end else if (bus.branch_en) begin
                    // Relative add wraps naturally at PC_W bits, so the offset needs no extension.
                    pc_d  = bus.jump_abs ? lut_entry : pc_q + lut_entry;
                    cnt_d = cnt_inc;
                end else begin
                    if (pc_q == LAST_PC) begin
                        state_d = DONE;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                    cnt_d = cnt_inc;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
                cnt_d   = '0;
            end
        endcase
        done_d    = (state_d == DONE);
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            running_q <= running_d;
        end
    end

    assign bus.PC          = pc_q;
    assign bus.done        = done_q;
    assign bus.running     = running_q;
    assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_prog_counter.sv
// Directed bench for prog_counter: a full-length program, a 16-entry program and a 3-bit counter build.
module tb_prog_counter;

    logic clk;
    logic reset_n;
    int   compared;
    int   mismatched;

    prog_counter_if                 m_if ();
    prog_counter_if                 s_if ();
    prog_counter_if #(.CNT_W(3))    t_if ();

    prog_counter u_main (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (m_if)
    );

    prog_counter #(.PROG_LEN(16)) u_short (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (s_if)
    );

    prog_counter #(.CNT_W(3)) u_sat (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (t_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset_n    = 1'b0;
        {m_if.start, m_if.stall, m_if.branch_en, m_if.jump_abs, m_if.halt} = '0;
        {s_if.start, s_if.stall, s_if.branch_en, s_if.jump_abs, s_if.halt} = '0;
        {t_if.start, t_if.stall, t_if.branch_en, t_if.jump_abs, t_if.halt} = '0;
        m_if.lut_idx = '0;
        s_if.lut_idx = '0;
        t_if.lut_idx = '0;

        applyStimulus(2);
        checkOutput("reset_pc",      32'(m_if.PC), 32'h0);
        checkOutput("reset_done",    32'(m_if.done), 32'h0);
        checkOutput("reset_running", 32'(m_if.running), 32'h0);
        checkOutput("reset_count",   32'(m_if.instr_count), 32'h0);

        reset_n    = 1'b1;
        m_if.start = 1'b1;
        applyStimulus(1);
        m_if.start = 1'b0;
        checkOutput("start_pc",      32'(m_if.PC), 32'h0);
        checkOutput("start_running", 32'(m_if.running), 32'h1);
        checkOutput("start_count",   32'(m_if.instr_count), 32'h0);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1);
            checkOutput("free_pc", 32'(m_if.PC), 32'(i));
        end
        checkOutput("free_running", 32'(m_if.running), 32'h1);
        checkOutput("free_count",   32'(m_if.instr_count), 32'd5);

        applyStimulus(5);
        checkOutput("pc_ten", 32'(m_if.PC), 32'd10);
        m_if.branch_en = 1'b1;
        m_if.jump_abs  = 1'b0;
        m_if.lut_idx   = 4'd3;
        applyStimulus(1);
        checkOutput("rel_back_pc",    32'(m_if.PC), 32'd6);
        checkOutput("rel_back_count", 32'(m_if.instr_count), 32'd11);

        m_if.jump_abs = 1'b1;
        m_if.lut_idx  = 4'd2;
        applyStimulus(1);
        checkOutput("abs_to_two", 32'(m_if.PC), 32'd2);
        m_if.jump_abs = 1'b0;
        m_if.lut_idx  = 4'd3;
        applyStimulus(1);
        checkOutput("rel_wrap_pc", 32'(m_if.PC), 32'd254);
        m_if.branch_en = 1'b0;
        applyStimulus(1);
        checkOutput("last_pc",    32'(m_if.PC), 32'd255);
        checkOutput("last_count", 32'(m_if.instr_count), 32'd14);

        m_if.branch_en = 1'b1;
        m_if.jump_abs  = 1'b1;
        m_if.lut_idx   = 4'd1;
        applyStimulus(1);
        checkOutput("branch_from_last_pc",      32'(m_if.PC), 32'd20);
        checkOutput("branch_from_last_running", 32'(m_if.running), 32'h1);

        m_if.stall   = 1'b1;
        m_if.lut_idx = 4'd5;
        applyStimulus(1);
        checkOutput("stall_pc",    32'(m_if.PC), 32'd20);
        checkOutput("stall_count", 32'(m_if.instr_count), 32'd15);
        m_if.stall = 1'b0;
        applyStimulus(1);
        checkOutput("abs_pc",    32'(m_if.PC), 32'd128);
        checkOutput("abs_count", 32'(m_if.instr_count), 32'd16);

        m_if.lut_idx = 4'd7;
        applyStimulus(1);
        checkOutput("abs_to_seven", 32'(m_if.PC), 32'd7);
        m_if.branch_en = 1'b0;
        m_if.halt      = 1'b1;
        applyStimulus(1);
        checkOutput("halt_pc",      32'(m_if.PC), 32'd7);
        checkOutput("halt_done",    32'(m_if.done), 32'h1);
        checkOutput("halt_running", 32'(m_if.running), 32'h0);
        checkOutput("halt_count",   32'(m_if.instr_count), 32'd18);
        m_if.branch_en = 1'b1;
        m_if.lut_idx   = 4'd5;
        applyStimulus(1);
        checkOutput("done_ignores_pc",    32'(m_if.PC), 32'd7);
        checkOutput("done_ignores_count", 32'(m_if.instr_count), 32'd18);
        m_if.branch_en = 1'b0;
        m_if.halt      = 1'b0;

        m_if.start = 1'b1;
        applyStimulus(1);
        m_if.start = 1'b0;
        checkOutput("restart_pc",   32'(m_if.PC), 32'h0);
        checkOutput("restart_done", 32'(m_if.done), 32'h0);
        applyStimulus(1);
        checkOutput("restart_step", 32'(m_if.PC), 32'h1);
        m_if.halt  = 1'b1;
        m_if.start = 1'b1;
        applyStimulus(1);
        m_if.halt  = 1'b0;
        m_if.start = 1'b0;
        checkOutput("start_beats_halt_pc",      32'(m_if.PC), 32'h0);
        checkOutput("start_beats_halt_running", 32'(m_if.running), 32'h1);
        checkOutput("start_beats_halt_count",   32'(m_if.instr_count), 32'h0);

        m_if.branch_en = 1'b1;
        m_if.jump_abs  = 1'b1;
        m_if.lut_idx   = 4'd10;
        applyStimulus(1);
        m_if.branch_en = 1'b0;
        checkOutput("pc_forty", 32'(m_if.PC), 32'd40);
        reset_n    = 1'b0;
        m_if.start = 1'b1;
        applyStimulus(1);
        checkOutput("midrun_reset_pc",      32'(m_if.PC), 32'h0);
        checkOutput("midrun_reset_running", 32'(m_if.running), 32'h0);
        checkOutput("midrun_reset_done",    32'(m_if.done), 32'h0);
        checkOutput("midrun_reset_count",   32'(m_if.instr_count), 32'h0);
        reset_n    = 1'b1;
        m_if.start = 1'b0;
        applyStimulus(1);
        checkOutput("idle_after_reset", 32'(m_if.running), 32'h0);

        s_if.start = 1'b1;
        t_if.start = 1'b1;
        applyStimulus(1);
        s_if.start = 1'b0;
        t_if.start = 1'b0;
        applyStimulus(15);
        checkOutput("short_pc_end",  32'(s_if.PC), 32'd15);
        checkOutput("short_running", 32'(s_if.running), 32'h1);
        applyStimulus(1);
        checkOutput("short_done",         32'(s_if.done), 32'h1);
        checkOutput("short_done_running", 32'(s_if.running), 32'h0);
        checkOutput("short_done_pc",      32'(s_if.PC), 32'd15);
        checkOutput("short_done_count",   32'(s_if.instr_count), 32'd16);
        checkOutput("sat_count",          32'(t_if.instr_count), 32'd7);
        checkOutput("sat_pc",             32'(t_if.PC), 32'd16);
        applyStimulus(1);
        checkOutput("short_hold_pc", 32'(s_if.PC), 32'd15);
        s_if.start = 1'b1;
        applyStimulus(1);
        s_if.start = 1'b0;
        checkOutput("short_restart_pc",   32'(s_if.PC), 32'h0);
        checkOutput("short_restart_done", 32'(s_if.done), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
